// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver/transmitter, mode 0, oversampled in the clk domain.
// sck/sdi/load are synchronised and edge-detected; nothing is clocked by sck.
// The last good frame is double-buffered in frame_data.
// Optional feature: define SPI_FRAME_CRC8_EN to treat the last 8 frame bits as
// a CRC-8 (poly 0x07, init 0x00, MSB first) over the preceding bits.
module spi_frame_rx #(
   parameter int FRAME_BITS  = 128,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sck,
   input  logic                  sdi,
   input  logic                  load,
   input  logic [FRAME_BITS-1:0] tx_data,
   output logic                  sdo,
   output logic                  busy,
   output logic [FRAME_BITS-1:0] frame_data,
   output logic                  frame_valid,
   output logic                  frame_err,
   output logic [CNT_W-1:0]      frame_cnt
);

   localparam int BW = $clog2(FRAME_BITS + 1);
   localparam int SW = $clog2(SYNC_STAGES + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
   localparam logic [SW-1:0] SETTLED  = SW'(SYNC_STAGES);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_FULL = 2'd2} state_t;

   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  sck_sync_q, sck_sync_d, sdi_sync_q, sdi_sync_d, load_sync_q, load_sync_d;
   logic                    sck_prev_q, sck_prev_d, sdi_prev_q, sdi_prev_d, load_prev_q, load_prev_d;
   logic [SW-1:0]           settle_q, settle_d;
   logic                    load_arm_q, load_arm_d;
   logic [FRAME_BITS-1:0]   rx_shreg_q, rx_shreg_d, tx_shreg_q, tx_shreg_d;
   logic [FRAME_BITS-1:0]   frame_data_q, frame_data_d;
   logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
   logic                    overrun_q, overrun_d;
   logic                    sdo_q, sdo_d, busy_q, busy_d;
   logic                    frame_valid_q, frame_valid_d, frame_err_q, frame_err_d;
   logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;
   logic                    sck_rise, sck_fall, load_rise, load_fall, frame_ok;

`ifdef SPI_FRAME_CRC8_EN
   logic [7:0]              crc_q, crc_d;

   // One MSB-first CRC-8 step, poly x^8+x^2+x+1.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
      logic fb;
      fb = crc[7] ^ bit_in;
      crc8_step = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
   endfunction

   // Running the CRC over the appended checksum leaves a zero residue on a good frame.
   assign frame_ok = ~overrun_q & (crc_q == 8'h00);
`else
   assign frame_ok = ~overrun_q;
`endif

   assign sck_rise  = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
   assign sck_fall  = ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
   // A load that is already high when reset drops must not look like a frame start,
   // so rises are only honoured once load has been seen low after the chain settled.
   assign load_rise = load_sync_q[SYNC_STAGES-1] & ~load_prev_q & load_arm_q;
   assign load_fall = ~load_sync_q[SYNC_STAGES-1] & load_prev_q;

   // Synchroniser chains, edge-detect history and load re-arm tracking.
   always_comb begin
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
      sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      load_sync_d = {load_sync_q[SYNC_STAGES-2:0], load};
      sck_prev_d  = sck_sync_q[SYNC_STAGES-1];
      sdi_prev_d  = sdi_sync_q[SYNC_STAGES-1];
      load_prev_d = load_sync_q[SYNC_STAGES-1];
      if (settle_q == SETTLED) begin
         settle_d   = settle_q;
         load_arm_d = load_arm_q | ~load_sync_q[SYNC_STAGES-1];
      end else begin
         settle_d   = settle_q + SW'(1);
         load_arm_d = load_arm_q;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; load_fall takes priority over any sck edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (load_rise) state_d = ST_SHIFT;
            else           state_d = ST_IDLE;
         end
         ST_SHIFT: begin
            if (load_fall)                             state_d = ST_IDLE;
            else if (sck_rise && bit_cnt_q == LAST_BIT) state_d = ST_FULL;
            else                                       state_d = ST_SHIFT;
         end
         ST_FULL: begin
            if (load_fall) state_d = ST_IDLE;
            else           state_d = ST_FULL;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM output/datapath logic: shift registers, counters and registered outputs.
   always_comb begin
      rx_shreg_d    = rx_shreg_q;
      tx_shreg_d    = tx_shreg_q;
      bit_cnt_d     = bit_cnt_q;
      overrun_d     = overrun_q;
      sdo_d         = sdo_q;
      frame_data_d  = frame_data_q;
      frame_cnt_d   = frame_cnt_q;
      frame_valid_d = 1'b0;
      frame_err_d   = 1'b0;
      busy_d        = (state_d != ST_IDLE);
`ifdef SPI_FRAME_CRC8_EN
      crc_d         = crc_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (load_rise) begin
               bit_cnt_d  = '0;
               overrun_d  = 1'b0;
               tx_shreg_d = tx_data;
               sdo_d      = tx_data[FRAME_BITS-1];
`ifdef SPI_FRAME_CRC8_EN
               crc_d      = 8'h00;
`endif
            end else begin
               sdo_d = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (load_fall) begin
               frame_err_d = 1'b1;
               sdo_d       = 1'b0;
            end else if (sck_rise) begin
               rx_shreg_d = {rx_shreg_q[FRAME_BITS-2:0], sdi_prev_q};
               bit_cnt_d  = bit_cnt_q + BW'(1);
`ifdef SPI_FRAME_CRC8_EN
               crc_d      = crc8_step(crc_q, sdi_prev_q);
`endif
               if (bit_cnt_q == LAST_BIT) sdo_d = 1'b0;
               else                       sdo_d = sdo_q;
            end else if (sck_fall) begin
               tx_shreg_d = {tx_shreg_q[FRAME_BITS-2:0], 1'b0};
               sdo_d      = tx_shreg_q[FRAME_BITS-2];
            end else begin
               sdo_d = sdo_q;
            end
         end
         ST_FULL: begin
            sdo_d = 1'b0;
            if (load_fall) begin
               if (frame_ok) begin
                  frame_data_d  = rx_shreg_q;
                  frame_valid_d = 1'b1;
                  frame_cnt_d   = frame_cnt_q + CNT_W'(1);
               end else begin
                  frame_err_d = 1'b1;
               end
            end else if (sck_rise) begin
               overrun_d = 1'b1;
            end else begin
               overrun_d = overrun_q;
            end
         end
         default: begin
            sdo_d = 1'b0;
         end
      endcase
   end

   // Datapath and input-conditioning registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sck_sync_q    <= '0;
         sdi_sync_q    <= '0;
         load_sync_q   <= '0;
         sck_prev_q    <= 1'b0;
         sdi_prev_q    <= 1'b0;
         load_prev_q   <= 1'b0;
         settle_q      <= '0;
         load_arm_q    <= 1'b0;
         rx_shreg_q    <= '0;
         tx_shreg_q    <= '0;
         bit_cnt_q     <= '0;
         overrun_q     <= 1'b0;
         sdo_q         <= 1'b0;
         busy_q        <= 1'b0;
         frame_data_q  <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         frame_cnt_q   <= '0;
`ifdef SPI_FRAME_CRC8_EN
         crc_q         <= 8'h00;
`endif
      end else begin
         sck_sync_q    <= sck_sync_d;
         sdi_sync_q    <= sdi_sync_d;
         load_sync_q   <= load_sync_d;
         sck_prev_q    <= sck_prev_d;
         sdi_prev_q    <= sdi_prev_d;
         load_prev_q   <= load_prev_d;
         settle_q      <= settle_d;
         load_arm_q    <= load_arm_d;
         rx_shreg_q    <= rx_shreg_d;
         tx_shreg_q    <= tx_shreg_d;
         bit_cnt_q     <= bit_cnt_d;
         overrun_q     <= overrun_d;
         sdo_q         <= sdo_d;
         busy_q        <= busy_d;
         frame_data_q  <= frame_data_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
         frame_cnt_q   <= frame_cnt_d;
`ifdef SPI_FRAME_CRC8_EN
         crc_q         <= crc_d;
`endif
      end
   end

   assign sdo         = sdo_q;
   assign busy        = busy_q;
   assign frame_data  = frame_data_q;
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
Parametrised SPI slave frame receiver and transmitter, fully synchronous to the system clock.
- sck, sdi and load are oversampled through synchronisers in the clk domain; no logic is clocked by sck.
- Captures a FRAME_BITS-wide frame MSB-first and shifts a tx word out on sdo.
- Validates frame length and double-buffers the last good frame for downstream consumers such as the VGA/drawing logic.

Parameters:
FRAME_BITS, 128, bits per frame, MSB first; must be ≥ 16.
SYNC_STAGES, 2, flops per input synchroniser; must be ≥ 2.
CNT_W, 8, width of the good-frame counter.

Ports:
clk  input  1  system clock (internal oscillator domain)
reset  input  1  synchronous, active-high reset
sck  input  1  SPI clock from MCU, asynchronous; mode 0
sdi  input  1  SPI data from MCU, asynchronous
load  input  1  active-high frame enable from MCU, asynchronous; high for the whole frame
tx_data  input  FRAME_BITS  word to return on sdo; latched at frame start
sdo  output  1  SPI data to MCU
busy  output  1  frame in progress
frame_data  output  FRAME_BITS  last good frame; holds its value until the next good frame
frame_valid  output  1  one-clk pulse when frame_data updates
frame_err  output  1  one-clk pulse on a rejected frame
frame_cnt  output  CNT_W  good-frame count; wraps 2^CNT_W-1 → 0

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - sdo=0, busy=0, frame_data=0, frame_valid=0, frame_err=0, frame_cnt=0.
  - State is IDLE; shift registers, bit counter and overrun flag are 0.
  - Synchroniser and edge-detect flops are loaded with 0.
- Input conditioning and timing:
  - sck, sdi and load each pass through SYNC_STAGES flops plus one edge-detect flop.
  - sck_rise, sck_fall, load_rise and load_fall are single-clk pulses.
  - Pin-to-action latency is SYNC_STAGES+1 clks.
  - Requirement on the MCU: sck high and low phases ≥ SYNC_STAGES+2 clk periods each.
- FSM IDLE:
  - busy=0; sck edges are ignored.
  - On load_rise: go to SHIFT; bit_cnt=0; overrun=0; tx_shreg=tx_data; sdo=tx_data[FRAME_BITS-1].
- FSM SHIFT:
  - busy=1.
  - On sck_rise: rx_shreg={rx_shreg[FRAME_BITS-2:0], sdi_sync}; bit_cnt++.
  - On sck_fall: tx_shreg shifts left by 1; sdo=new MSB, zero-filled.
  - When bit_cnt reaches FRAME_BITS, go to FULL.
  - On load_fall: go to IDLE; frame_err pulse (short frame); frame_data and frame_cnt unchanged.
- FSM FULL:
  - busy=1; sdo=0.
  - On sck_rise: overrun=1; rx_shreg unchanged.
  - On load_fall with overrun=0: frame_data=rx_shreg; frame_valid pulse; frame_cnt++ (wrapping); go to IDLE.
  - On load_fall with overrun=1: frame_err pulse; go to IDLE.
  - frame_valid/frame_err assert the clk after load_fall is detected.
- Simultaneous events: load_fall and sck_rise in the same clk → load_fall wins and the sck edge is discarded.
- Reset mid-frame:
  - Everything returns to IDLE with reset values.
  - If load is still high when reset drops, no load_rise occurs, so the frame is ignored until load goes low and then high again.
- bit_cnt is $clog2(FRAME_BITS+1) bits wide; it never wraps.
- frame_valid and frame_err are never high in the same cycle.

Optional Feature:
- Macro: SPI_FRAME_CRC8_EN.
- When defined:
  - The last 8 frame bits are a CRC-8 over the first FRAME_BITS-8 bits: poly 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - The CRC is computed incrementally on each sck_rise.
  - In FULL, on load_fall with overrun=0:
    - CRC match → normal frame_valid.
    - CRC mismatch → frame_err; frame_data unchanged.
- When undefined: no CRC logic; all FRAME_BITS bits are payload.

Test Plan:
- Reset, then a 128-bit frame with sdi=0x0123456789ABCDEF_FEDCBA9876543210, load dropped after 128 sck → one frame_valid pulse; frame_data equals that value; frame_cnt=1; busy=0.
- Good frame A, then a 100-sck frame with load dropped early → frame_err pulse; frame_data still A; frame_cnt=1; no frame_valid.
- 130 sck in one frame → frame_err pulse; frame_data and frame_cnt unchanged.
- tx_data=0xA5A5…A5, master samples sdo on each sck rise → received 128 bits equal 0xA5A5…A5.
- Reset pulsed after 64 sck with load held high, 64 more sck, then a clean 128-bit frame → the first frame produces no pulse; the second frame produces frame_valid with correct data; frame_cnt=1.
- SPI_FRAME_CRC8_EN, FRAME_BITS=16:
  - Frame 0x3197 → frame_valid, frame_data=0x3197.
  - Frame 0x3196 → frame_err, frame_data unchanged.
  - 256 good frames → frame_cnt wraps to 0.
